fifo_wrt_frontend: RTL and testbench

Write-side front end of the asynchronous FIFO, in the `wrt_clk` domain. Sits directly upstream of the write pointer generator. Absorbs a valid/ready producer stream into a 2-entry skid buffer and issues one-per-cycle `wrt_inc`/`wrt_data` writes gated by `wrt_full`. Converts the gray write pointer and synchronized read pointer to binary to produce a registered fill level and almost-full flag.

---
 rtl/fifo_wrt_frontend.sv | 122 ++++++++++++
 tb/tb_fifo_wrt_frontend.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wrt_frontend.sv
// fifo_wrt_frontend: write-side skid buffer and fill-level tracker for the async FIFO (wrt_clk domain).
// Define FIFO_WRT_LEVEL_EN to build the gray-to-binary fill level and almost-full compare.
module fifo_wrt_frontend #(
    parameter int DATA_SIZE    = 8,
    parameter int ADDR_SIZE    = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                 wrt_clk,
    input  logic                 wrt_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 wrt_full,
    input  logic [ADDR_SIZE:0]   wrt_ptr,
    input  logic [ADDR_SIZE:0]   sync_rd_ptr,
    output logic                 wrt_inc,
    output logic [DATA_SIZE-1:0] wrt_data,
    output logic [ADDR_SIZE:0]   wrt_level,
    output logic                 wrt_almost_full
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]           state, state_nxt;
    logic [DATA_SIZE-1:0] head_q, head_nxt;
    logic [DATA_SIZE-1:0] tail_q, tail_nxt;
    logic                 accept, drain;

    assign accept   = in_valid & in_ready;
    assign drain    = (state != ST_EMPTY) & ~wrt_full;
    assign wrt_inc  = drain;
    assign wrt_data = head_q;

    always_comb begin
        state_nxt = state;
        head_nxt  = head_q;
        tail_nxt  = tail_q;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_ONE;
                    head_nxt  = in_data;
                end
            end
            ST_ONE: begin
                if (accept && !drain) begin
                    state_nxt = ST_TWO;
                    tail_nxt  = in_data;
                end else if (drain && !accept) begin
                    state_nxt = ST_EMPTY;
                end else if (accept && drain) begin
                    head_nxt  = in_data;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can move the state
                if (drain) begin
                    state_nxt = ST_ONE;
                    head_nxt  = tail_q;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge wrt_clk or posedge wrt_rst) begin
        if (wrt_rst) begin
            state    <= ST_EMPTY;
            head_q   <= '0;
            tail_q   <= '0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            head_q   <= head_nxt;
            tail_q   <= tail_nxt;
            in_ready <= (state_nxt != ST_TWO);
        end
    end

`ifdef FIFO_WRT_LEVEL_EN
    localparam int PW = ADDR_SIZE + 1;
    localparam logic [PW-1:0] THRESH = PW'(AFULL_THRESH);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = '0;
        b[PW-1] = g[PW-1];
        for (int unsigned i = 1; i < PW; i++) begin
            b[PW-1-i] = b[PW-i] ^ g[PW-1-i];
        end
        return b;
    endfunction

    logic [PW-1:0] wr_bin, rd_bin, level_nxt;

    assign wr_bin    = gray2bin(wrt_ptr);
    assign rd_bin    = gray2bin(sync_rd_ptr);
    // Modular subtraction at pointer width absorbs the wrap of either pointer
    assign level_nxt = wr_bin - rd_bin;

    always_ff @(posedge wrt_clk or posedge wrt_rst) begin
        if (wrt_rst) begin
            wrt_level       <= '0;
            wrt_almost_full <= 1'b0;
        end else begin
            wrt_level       <= level_nxt;
            wrt_almost_full <= (level_nxt >= THRESH);
        end
    end
`else
    logic unused_ptrs;

    assign unused_ptrs     = ^{wrt_ptr, sync_rd_ptr};
    assign wrt_level       = '0;
    assign wrt_almost_full = wrt_full;
`endif

endmodule

// File: tb/tb_fifo_wrt_frontend.sv
// Self-checking bench for fifo_wrt_frontend against a queue-based reference model.
// Honours FIFO_WRT_LEVEL_EN the same way as the design.
module tb_fifo_wrt_frontend;

    localparam int DATA_SIZE    = 8;
    localparam int ADDR_SIZE    = 4;
    localparam int AFULL_THRESH = 12;
    localparam int PMOD         = 1 << (ADDR_SIZE + 1);

    logic                 wrt_clk = 1'b0;
    logic                 wrt_rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] in_data = '0;
    logic                 wrt_full = 1'b0;
    logic [ADDR_SIZE:0]   wrt_ptr = '0;
    logic [ADDR_SIZE:0]   sync_rd_ptr = '0;
    logic                 wrt_inc;
    logic [DATA_SIZE-1:0] wrt_data;
    logic [ADDR_SIZE:0]   wrt_level;
    logic                 wrt_almost_full;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of buffered words, expected flops
    logic [DATA_SIZE-1:0] model_q[$];
    logic                 exp_ready = 1'b0;
    logic [ADDR_SIZE:0]   exp_level = '0;
    logic                 exp_afull = 1'b0;

    fifo_wrt_frontend #(
        .DATA_SIZE(DATA_SIZE),
        .ADDR_SIZE(ADDR_SIZE),
        .AFULL_THRESH(AFULL_THRESH)
    ) dut (
        .wrt_clk(wrt_clk),
        .wrt_rst(wrt_rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .wrt_full(wrt_full),
        .wrt_ptr(wrt_ptr),
        .sync_rd_ptr(sync_rd_ptr),
        .wrt_inc(wrt_inc),
        .wrt_data(wrt_data),
        .wrt_level(wrt_level),
        .wrt_almost_full(wrt_almost_full)
    );

    always #5 wrt_clk = ~wrt_clk;

    // Gray decode by search: the binary value whose gray code matches
    function automatic int gray_to_int(input logic [ADDR_SIZE:0] g);
        for (int b = 0; b < PMOD; b++) begin
            if (((b ^ (b >> 1)) & (PMOD - 1)) == int'(g)) return b;
        end
        return 0;
    endfunction

    function automatic logic exp_inc();
        return (model_q.size() != 0) && !wrt_full;
    endfunction

    function automatic logic exp_af();
`ifdef FIFO_WRT_LEVEL_EN
        return exp_afull;
`else
        return wrt_full;
`endif
    endfunction

    // Advance model and DUT across one rising edge; returns at the next falling edge
    task automatic advance();
        logic acc, drn;
        int   lv;
        acc = in_valid && exp_ready;
        drn = exp_inc();
        lv  = (gray_to_int(wrt_ptr) - gray_to_int(sync_rd_ptr) + PMOD) % PMOD;
        @(posedge wrt_clk);
        if (drn) void'(model_q.pop_front());
        if (acc) model_q.push_back(in_data);
        exp_ready = (model_q.size() < 2);
`ifdef FIFO_WRT_LEVEL_EN
        exp_level = lv[ADDR_SIZE:0];
        exp_afull = (lv >= AFULL_THRESH);
`else
        exp_level = '0;
        exp_afull = 1'b0;
`endif
        @(negedge wrt_clk);
    endtask

    task automatic test_reset();
        @(negedge wrt_clk);
        #1;
        n_checks++;
        if ({in_ready, wrt_inc, wrt_level, wrt_almost_full, wrt_data} !== '0)
            begin n_fail++; $display("FAIL reset_init: got rdy=%b inc=%b lvl=%0d af=%b data=%h, want all 0",
                in_ready, wrt_inc, wrt_level, wrt_almost_full, wrt_data); end
        @(negedge wrt_clk);
        wrt_rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", in_ready); end
        advance();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_first_edge: got %b want 1", in_ready); end
    endtask

    task automatic test_streaming();
        int n_inc = 0;
        for (int i = 1; i <= 19; i++) begin
            in_valid = (i <= 16);
            in_data  = DATA_SIZE'(i);
            wrt_full = 1'b0;
            #1;
            n_checks++;
            if (wrt_inc !== exp_inc()) begin n_fail++; $display("FAIL stream_inc[%0d]: got %b want %b", i, wrt_inc, exp_inc()); end
            if (wrt_inc === 1'b1) begin
                n_inc++;
                n_checks++;
                if (wrt_data !== DATA_SIZE'(i - 1)) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, wrt_data, DATA_SIZE'(i - 1)); end
            end
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
            advance();
        end
        n_checks++;
        if (n_inc != 16) begin n_fail++; $display("FAIL stream_count: got %0d writes want 16", n_inc); end
    endtask

    task automatic test_backpressure();
        logic [DATA_SIZE-1:0] held;
        for (int i = 0; i < 16; i++) begin
            in_valid = (i < 10);
            in_data  = DATA_SIZE'($urandom);
            wrt_full = (i >= 3 && i < 7);
            #1;
            if (i == 5) begin
                n_checks++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
            end
            if (i == 3) held = wrt_data;
            n_checks++;
            if (wrt_inc !== exp_inc()) begin n_fail++; $display("FAIL bp_inc[%0d]: got %b want %b", i, wrt_inc, exp_inc()); end
            if (model_q.size() != 0) begin
                n_checks++;
                if (wrt_data !== model_q[0]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, wrt_data, model_q[0]); end
            end
            if (i > 3 && i < 7) begin
                n_checks++;
                if (wrt_data !== held) begin n_fail++; $display("FAIL bp_stable[%0d]: got %h want %h", i, wrt_data, held); end
            end
            n_checks++;
            if (in_ready !== exp_ready) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want %b", i, in_ready, exp_ready); end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        logic [DATA_SIZE-1:0] fresh;
        in_valid = 1'b1; wrt_full = 1'b1; in_data = 8'hA5;
        advance();
        in_data = 8'h5A;
        advance();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_two_ready: got %b want 0", in_ready); end
        #1;
        wrt_rst = 1'b1; wrt_full = 1'b0;
        #1;
        model_q.delete();
        exp_ready = 1'b0; exp_level = '0; exp_afull = 1'b0;
        n_checks++;
        if ({in_ready, wrt_inc, wrt_level, wrt_almost_full, wrt_data} !== '0)
            begin n_fail++; $display("FAIL mid_reset_async: got rdy=%b inc=%b lvl=%0d af=%b data=%h, want all 0",
                in_ready, wrt_inc, wrt_level, wrt_almost_full, wrt_data); end
        @(negedge wrt_clk);
        wrt_rst = 1'b0;
        advance();
        n_checks++;
        if (in_ready !== 1'b1 || wrt_inc !== 1'b0) begin n_fail++; $display("FAIL mid_release: got rdy=%b inc=%b want 1 0", in_ready, wrt_inc); end
        fresh = 8'h3C;
        in_valid = 1'b1; in_data = fresh;
        advance();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (wrt_inc !== 1'b1 || wrt_data !== fresh) begin n_fail++; $display("FAIL mid_fresh: got inc=%b data=%h want 1 %h", wrt_inc, wrt_data, fresh); end
        advance();
        #1;
        n_checks++;
        if (wrt_inc !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale: got inc=%b data=%h want inc 0", wrt_inc, wrt_data); end
    endtask

    task automatic test_level();
        logic [ADDR_SIZE:0] wp[3] = '{5'b01011, 5'b01110, 5'b00010};
        logic [ADDR_SIZE:0] rp[3] = '{5'b00000, 5'b00000, 5'b10001};
        int                 lv[3] = '{13, 11, 5};
        logic               af[3] = '{1'b1, 1'b0, 1'b0};
        in_valid = 1'b0; wrt_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wrt_ptr = wp[i]; sync_rd_ptr = rp[i];
            advance();
            #1;
`ifdef FIFO_WRT_LEVEL_EN
            n_checks++;
            if (wrt_level !== ADDR_SIZE'(lv[i])) begin n_fail++; $display("FAIL level[%0d]: got %0d want %0d", i, wrt_level, lv[i]); end
            n_checks++;
            if (wrt_almost_full !== af[i]) begin n_fail++; $display("FAIL afull[%0d]: got %b want %b", i, wrt_almost_full, af[i]); end
`else
            n_checks++;
            if (wrt_level !== '0) begin n_fail++; $display("FAIL level_off[%0d]: got %0d want 0 (lvl %0d af %b unused)", i, wrt_level, lv[i], af[i]); end
            wrt_full = 1'b1;
            #1;
            n_checks++;
            if (wrt_almost_full !== 1'b1) begin n_fail++; $display("FAIL afull_tracks_hi[%0d]: got %b want 1", i, wrt_almost_full); end
            wrt_full = 1'b0;
            #1;
            n_checks++;
            if (wrt_almost_full !== 1'b0) begin n_fail++; $display("FAIL afull_tracks_lo[%0d]: got %b want 0", i, wrt_almost_full); end
`endif
            @(negedge wrt_clk);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            in_data     = DATA_SIZE'($urandom);
            wrt_full    = ($urandom_range(0, 9) < 3);
            wrt_ptr     = (ADDR_SIZE + 1)'($urandom);
            sync_rd_ptr = (ADDR_SIZE + 1)'($urandom);
            #1;
            n_checks++;
            if (wrt_inc !== exp_inc()) begin n_fail++; $display("FAIL rnd_inc[%0d]: got %b want %b", i, wrt_inc, exp_inc()); end
            if (model_q.size() != 0) begin
                n_checks++;
                if (wrt_data !== model_q[0]) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", i, wrt_data, model_q[0]); end
            end
            n_checks++;
            if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, exp_ready); end
            n_checks++;
            if (wrt_level !== exp_level) begin n_fail++; $display("FAIL rnd_level[%0d]: got %0d want %0d", i, wrt_level, exp_level); end
            n_checks++;
            if (wrt_almost_full !== exp_af()) begin n_fail++; $display("FAIL rnd_afull[%0d]: got %b want %b", i, wrt_almost_full, exp_af()); end
            advance();
        end
        in_valid = 1'b0; wrt_full = 1'b0;
        advance();
        advance();
        n_checks++;
        if (wrt_inc !== 1'b0 || model_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got inc=%b, model holds %0d want 0", wrt_inc, model_q.size()); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_reset_mid();
        test_level();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
